// File: rtl/mips_trace_pkg.sv
// Shared types and helpers for the MIPS PC trace capture unit.
package mips_trace_pkg;

  localparam int DROP_W = 16;

  // Channel-index width: at least one bit even for a single channel.
  function automatic int ch_w_f(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Entry layout for the default configuration (32-bit data, 2 channels, 16-bit ts).
  typedef struct packed {
    logic [31:0] data;
    logic [0:0]  ch;
    logic [15:0] ts;
  } trace_entry_t;

endpackage

// File: rtl/mips_trace_fifo.sv
// Synchronous FIFO with occupancy count and synchronous flush.
module mips_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push && !clear) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mips_pc_trace.sv
// Execution-trace capture: PC watch comparators, timestamp, drop accounting.
// Optional macro MIPS_TRACE_DEDUP_EN suppresses repeat hits on a held PC.
module mips_pc_trace
  import mips_trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  localparam int CH_W  = ch_w_f(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     enable,
  input  logic [ADDR_W-1:0]        pc_in,
  input  logic [DATA_W-1:0]        result_in,
  input  logic [NUM_CH*ADDR_W-1:0] watch_pc,
  input  logic [NUM_CH-1:0]        watch_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic [TS_W-1:0]          out_ts,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CH_W-1:0]   ch;
    logic [TS_W-1:0]   ts;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  logic [NUM_CH-1:0] w_hit_vec;
  logic              w_any;
  logic [CH_W-1:0]   w_ch;
  logic              w_dup;
  logic              w_hit;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  entry_t            w_din;
  entry_t            w_dout;
  logic [TS_W-1:0]   r_ts;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop_count;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      w_hit_vec[k] = watch_en[k] && (pc_in == watch_pc[k*ADDR_W +: ADDR_W]);
    end
  end

  // Scan from the top so the lowest hitting channel is the last to assign.
  always_comb begin
    w_any = 1'b0;
    w_ch  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (w_hit_vec[k]) begin
        w_any = 1'b1;
        w_ch  = CH_W'(k);
      end
    end
  end

`ifdef MIPS_TRACE_DEDUP_EN
  logic [ADDR_W-1:0] r_prev_pc;
  logic              r_prev_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_pc  <= '0;
      r_prev_vld <= 1'b0;
    end else if (clear) begin
      r_prev_pc  <= '0;
      r_prev_vld <= 1'b0;
    end else begin
      r_prev_pc  <= pc_in;
      r_prev_vld <= 1'b1;
    end
  end

  assign w_dup = r_prev_vld && (pc_in == r_prev_pc);
`else
  assign w_dup = 1'b0;
`endif

  assign w_hit  = enable && w_any && !w_dup;
  assign w_pop  = !w_empty && out_ready;
  assign w_push = w_hit && (!w_full || w_pop);
  assign w_drop = w_hit && w_full && !w_pop;

  assign w_din = '{data: result_in, ch: w_ch, ts: r_ts};

  mips_trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts         <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (clear) begin
      r_ts         <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
      if (w_drop) begin
        r_overflow   <= 1'b1;
        r_drop_count <= sat_inc(r_drop_count);
      end
    end
  end

  // Head fields read as zero whenever nothing is presented.
  assign out_valid  = !w_empty;
  assign out_data   = out_valid ? w_dout.data : '0;
  assign out_ch     = out_valid ? w_dout.ch   : '0;
  assign out_ts     = out_valid ? w_dout.ts   : '0;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule
